// File: rtl/halfstrip_checker_pkg.sv
// Shared definitions for the halfstrip checker: FSM state encodings and default sizes
// reused by the serial interface and comparator_injector.
package halfstrip_checker_pkg;

  typedef enum logic [1:0] {
    HSCHK_IDLE    = 2'd0,
    HSCHK_DELAY   = 2'd1,
    HSCHK_WINDOW  = 2'd2,
    HSCHK_COMPARE = 2'd3
  } hschk_state_e;

  localparam int NHS_DEF   = 32;
  localparam int CNT_W_DEF = 32;
  localparam int DLY_W_DEF = 4;

endpackage

// File: rtl/halfstrip_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/halfstrip_checker.sv
// Samples the decoded halfstrip hit word over a programmable BX window after each arm
// and compares it with the expected pattern. Optional feature macro: HSCHK_STICKY_EN.
module halfstrip_checker
  import halfstrip_checker_pkg::*;
#(
  parameter int NHS   = NHS_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic [DLY_W-1:0] window_start,
  input  logic [DLY_W-1:0] window_len,
  input  logic [NHS-1:0]   halfstrips,
  input  logic [NHS-1:0]   halfstrips_expect,
  input  logic [NHS-1:0]   active_strip_mask,
  input  logic             errcnt_rst,
  output logic             busy,
  output logic             done,
  output logic [NHS-1:0]   captured,
  output logic             mismatch,
  output logic [CNT_W-1:0] trials,
  output logic [CNT_W-1:0] errcnt
`ifdef HSCHK_STICKY_EN
  ,
  output logic [NHS-1:0]   sticky_mask
`endif
);

  hschk_state_e     state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] len_q, len_d;
  logic [NHS-1:0]   acc_q, acc_d;
  logic [NHS-1:0]   captured_q, captured_d;
  logic             mismatch_q, mismatch_d;
  logic             done_q, done_d;
  logic             trial_end;
  logic [NHS-1:0]   diff;

  assign diff = acc_q ^ (halfstrips_expect & active_strip_mask);

  // cnt_q counts down the remaining cycles of DELAY or WINDOW; zero means last cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    acc_d      = acc_q;
    captured_d = captured_q;
    mismatch_d = mismatch_q;
    done_d     = 1'b0;
    trial_end  = 1'b0;
    case (state_q)
      HSCHK_IDLE: begin
        if (arm) begin
          len_d = window_len;
          acc_d = '0;
          if (window_start != '0) begin
            state_d = HSCHK_DELAY;
            cnt_d   = window_start - DLY_W'(1);
          end else begin
            state_d = HSCHK_WINDOW;
            cnt_d   = window_len;
          end
        end
      end
      HSCHK_DELAY: begin
        if (cnt_q == '0) begin
          state_d = HSCHK_WINDOW;
          cnt_d   = len_q;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      HSCHK_WINDOW: begin
        acc_d = acc_q | (halfstrips & active_strip_mask);
        if (cnt_q == '0) begin
          state_d = HSCHK_COMPARE;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      HSCHK_COMPARE: begin
        state_d    = HSCHK_IDLE;
        captured_d = acc_q;
        mismatch_d = |diff;
        done_d     = 1'b1;
        trial_end  = 1'b1;
      end
      default: state_d = HSCHK_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HSCHK_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      acc_q      <= '0;
      captured_q <= '0;
      mismatch_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      captured_q <= captured_d;
      mismatch_q <= mismatch_d;
      done_q     <= done_d;
    end
  end

  // errcnt_rst wins over a same-cycle COMPARE increment inside sat_counter.
  sat_counter #(.W(CNT_W)) u_trials (
    .clk   (clk),
    .reset (reset),
    .clr   (errcnt_rst),
    .inc   (trial_end),
    .q     (trials)
  );

  sat_counter #(.W(CNT_W)) u_errcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (errcnt_rst),
    .inc   (trial_end & (|diff)),
    .q     (errcnt)
  );

`ifdef HSCHK_STICKY_EN
  logic [NHS-1:0] sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (errcnt_rst) begin
      sticky_d = '0;
    end else if (trial_end) begin
      sticky_d = sticky_q | diff;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky_mask = sticky_q;
`else
  // Without the sticky feature no per-strip history is kept.
`endif

  assign busy     = (state_q != HSCHK_IDLE);
  assign done     = done_q;
  assign captured = captured_q;
  assign mismatch = mismatch_q;

endmodule
